// File: rtl/lfa_pkg.sv
// Shared types and ADC128S022 frame constants for the line-follower ADC reader.
package lfa_pkg;

    typedef enum logic [1:0] {
        SEL_LEFT   = 2'd0,
        SEL_MIDDLE = 2'd1,
        SEL_RIGHT  = 2'd2
    } sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int FRAME_BITS   = 16;
    localparam int ADDR_MSB_POS = 13;
    localparam int DATA_BITS    = 12;
    localparam int HALF_PERIODS = 2 * FRAME_BITS;

    function automatic sel_t next_sel(input sel_t s);
        case (s)
            SEL_LEFT:   return SEL_MIDDLE;
            SEL_MIDDLE: return SEL_RIGHT;
            default:    return SEL_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCLK divider: idle-high clock, edge strobes coincident with each toggle,
// and a done strobe on the last (32nd) half-period of a frame.
module spi_sck_gen
    import lfa_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick,
    output logic done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(HALF_PERIODS);

    logic [CW-1:0] div_cnt;
    logic [HW-1:0] half_cnt;
    logic          term;

    assign term      = en && (div_cnt == CW'(CLK_DIV - 1));
    assign fall_tick = term && sck;
    assign rise_tick = term && !sck;
    assign done      = term && (half_cnt == HW'(HALF_PERIODS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            sck      <= 1'b1;
        end else if (!en) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            sck      <= 1'b1;
        end else if (term) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + HW'(1);
            sck      <= ~sck;
        end else begin
            div_cnt  <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lfa_adc_reader.sv
// ADC128S022 SPI master cycling the left/middle/right line sensors and
// presenting registered 12-bit results with a triple-complete strobe.
module lfa_adc_reader
    import lfa_pkg::*;
#(
    parameter int         CLK_DIV    = 16,
    parameter int         GAP_CYCLES = 32,
    parameter logic [2:0] CH_LEFT    = 3'd3,
    parameter logic [2:0] CH_MIDDLE  = 3'd4,
    parameter logic [2:0] CH_RIGHT   = 3'd5
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic [11:0] left,
    output logic [11:0] middle,
    output logic [11:0] right,
    output logic        data_valid
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t                state;
    sel_t                  sel;
    sel_t                  prev_sel;
    logic                  discard;
    logic                  dout_q;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] frame_word;
    logic [DATA_BITS-1:0]  rx_sr;
    logic [GW-1:0]         gap_cnt;
    logic [2:0]            cur_addr;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  frame_done;

    always_comb begin
        cur_addr = CH_LEFT;
        case (sel)
            SEL_MIDDLE: cur_addr = CH_MIDDLE;
            SEL_RIGHT:  cur_addr = CH_RIGHT;
            default:    cur_addr = CH_LEFT;
        endcase
    end

    assign frame_word = {2'b00, cur_addr, {(ADDR_MSB_POS - 2){1'b0}}};

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck (
        .clk      (clk_50M),
        .rst_n    (rst_n),
        .en       (state == FRAME),
        .sck      (adc_sck),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .done     (frame_done)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adc_cs_n   <= 1'b1;
            adc_din    <= 1'b0;
            left       <= '0;
            middle     <= '0;
            right      <= '0;
            data_valid <= 1'b0;
            sel        <= SEL_LEFT;
            prev_sel   <= SEL_LEFT;
            discard    <= 1'b1;
            tx_sr      <= '0;
            rx_sr      <= '0;
            gap_cnt    <= '0;
            dout_q     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            dout_q     <= adc_dout;
            unique case (state)
                IDLE: begin
                    adc_cs_n <= 1'b0;
                    tx_sr    <= frame_word;
                    state    <= FRAME;
                end
                FRAME: begin
                    if (fall_tick) begin
                        adc_din <= tx_sr[FRAME_BITS-1];
                        tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end
                    // Only the trailing 12 samples survive the shift.
                    if (rise_tick)
                        rx_sr <= {rx_sr[DATA_BITS-2:0], dout_q};
                    if (frame_done)
                        state <= LATCH;
                end
                LATCH: begin
                    adc_cs_n <= 1'b1;
                    adc_din  <= 1'b0;
                    gap_cnt  <= '0;
                    state    <= GAP;
                    // Data in this frame belongs to the previous address.
                    if (discard) begin
                        discard <= 1'b0;
                    end else begin
                        case (prev_sel)
                            SEL_LEFT:   left   <= rx_sr;
                            SEL_MIDDLE: middle <= rx_sr;
                            default: begin
                                right      <= rx_sr;
                                data_valid <= 1'b1;
                            end
                        endcase
                    end
                    prev_sel <= sel;
                    sel      <= next_sel(sel);
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES)) begin
                        adc_cs_n <= 1'b0;
                        tx_sr    <= frame_word;
                        state    <= FRAME;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfa_adc_reader.sv
// Directed bench for lfa_adc_reader with a behavioural ADC128S022 model.
module tb_lfa_adc_reader;

    logic        clk_50M  = 1'b0;
    logic        rst_n    = 1'b0;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        adc_din;
    logic [11:0] left;
    logic [11:0] middle;
    logic [11:0] right;
    logic        data_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [11:0] mem [8];
    logic        noise  = 1'b0;
    logic [2:0]  m_prev = 3'd0;
    logic [15:0] m_word = '0;
    logic [15:0] m_din  = '0;
    int          m_rise = 0;
    logic [2:0]  addr_log [8];
    int          n_addr = 0;

    lfa_adc_reader dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .adc_dout  (adc_dout),
        .adc_cs_n  (adc_cs_n),
        .adc_sck   (adc_sck),
        .adc_din   (adc_din),
        .left      (left),
        .middle    (middle),
        .right     (right),
        .data_valid(data_valid)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    // ADC model: converts the address received in the previous frame.
    always @(negedge adc_cs_n) begin
        m_rise   = 0;
        m_word   = {noise ? 4'hF : 4'h0, mem[m_prev]};
        adc_dout = 1'b0;
    end

    always @(negedge adc_sck) begin
        if (!adc_cs_n) begin
            adc_dout = m_word[15];
            m_word   = {m_word[14:0], 1'b0};
        end
    end

    always @(posedge adc_sck) begin
        if (!adc_cs_n) begin
            m_din  = {m_din[14:0], adc_din};
            m_rise = m_rise + 1;
            if (m_rise == 16) begin
                m_prev = m_din[13:11];
                if (n_addr < 8) begin
                    addr_log[n_addr] = m_din[13:11];
                    n_addr = n_addr + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   t0;
        int   t1;
        int   tv;
        int   rises;
        int   bad_per;
        int   last_rise;
        logic prev_sck;

        for (int i = 0; i < 8; i++) mem[i] = 12'h5A5;
        mem[3] = 12'h064;
        mem[4] = 12'hABC;
        mem[5] = 12'hFFF;

        repeat (4) @(negedge clk_50M);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sck", adc_sck, 1);
        check("rst_din", adc_din, 0);
        check("rst_left", left, 0);
        check("rst_middle", middle, 0);
        check("rst_right", right, 0);
        check("rst_valid", data_valid, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 20 && adc_cs_n; i++) @(negedge clk_50M);
        check("cs_fall", adc_cs_n, 0);
        t0 = cyc;

        for (int i = 0; i < 100 && adc_sck; i++) @(negedge clk_50M);
        check("sck_first_fall", cyc - t0, 16);

        rises = 0;
        bad_per = 0;
        last_rise = 0;
        prev_sck = adc_sck;
        for (int i = 0; i < 1000 && !adc_cs_n; i++) begin
            @(negedge clk_50M);
            if (adc_sck && !prev_sck) begin
                if (rises > 0 && (cyc - last_rise) != 32) bad_per++;
                rises++;
                last_rise = cyc;
            end
            prev_sck = adc_sck;
        end
        check("sck_rises", rises, 16);
        check("sck_period_bad", bad_per, 0);
        check("cs_low_len", cyc - t0, 513);
        check("sck_idle_high", adc_sck, 1);

        t1 = cyc;
        for (int i = 0; i < 100 && adc_cs_n; i++) @(negedge clk_50M);
        check("cs_high_len", cyc - t1, 33);

        for (int i = 0; i < 3000 && !data_valid; i++) @(negedge clk_50M);
        check("first_valid_time", cyc - t0, 2151);
        check("left_1", left, 12'h064);
        check("middle_1", middle, 12'hABC);
        check("right_1", right, 12'hFFF);
        tv = cyc;
        @(negedge clk_50M);
        check("valid_one_clock", data_valid, 0);

        for (int i = 0; i < 2000 && !data_valid; i++) @(negedge clk_50M);
        check("valid_interval_1", cyc - tv, 1638);
        check("din_addr_seq",
              {14'd0, addr_log[0], addr_log[1], addr_log[2],
               addr_log[3], addr_log[4], addr_log[5]},
              {14'd0, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5});

        tv = cyc;
        mem[4] = 12'h000;
        for (int i = 0; i < 1200 && middle == 12'hABC; i++) @(negedge clk_50M);
        check("middle_update_time", cyc - tv, 1092);
        check("middle_2", middle, 12'h000);
        check("left_2", left, 12'h064);
        check("right_2", right, 12'hFFF);

        for (int i = 0; i < 2000 && !data_valid; i++) @(negedge clk_50M);
        check("valid_interval_2", cyc - tv, 1638);
        check("left_3", left, 12'h064);
        check("right_3", right, 12'hFFF);

        tv = cyc;
        for (int i = 0; i < 1500 && (cyc - tv) < 1395; i++) @(negedge clk_50M);
        check("in_right_frame", adc_cs_n, 0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_left", left, 0);
        check("arst_middle", middle, 0);
        check("arst_right", right, 0);
        check("arst_cs_n", adc_cs_n, 1);
        check("arst_sck", adc_sck, 1);
        check("arst_valid", data_valid, 0);

        mem[3] = 12'h321;
        mem[4] = 12'h0F0;
        mem[5] = 12'h800;
        noise  = 1'b1;
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;

        for (int i = 0; i < 20 && adc_cs_n; i++) @(negedge clk_50M);
        check("cs_fall_2", adc_cs_n, 0);
        t0 = cyc;
        for (int i = 0; i < 1000 && !adc_cs_n; i++) @(negedge clk_50M);
        @(negedge clk_50M);
        check("discard_left", left, 0);
        check("discard_middle", middle, 0);
        check("discard_right", right, 0);

        for (int i = 0; i < 3000 && !data_valid; i++) @(negedge clk_50M);
        check("valid_after_reset", cyc - t0, 2151);
        check("left_noise", left, 12'h321);
        check("middle_noise", middle, 12'h0F0);
        check("right_noise", right, 12'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
